// File: rtl/tawas_rcn_load_return.sv
// tawas_rcn_load_return
//   Return stage between the Raccoon bus master and the register-file RACCOON_LOAD
//   write port. Load responses are queued in a small FIFO, formatted (byte/half
//   lane select with zero/sign extension, or word pass-through) and written at
//   most once per cycle. A 32-bit scoreboard tracks loads in flight per
//   {slice, register} so decode can stall on pending registers.
//
// Optional build macro: TAWAS_RCN_LOAD_BYPASS_EN
//   When defined, a response arriving into an empty FIFO with no LOAD_HOLD skips
//   the FIFO and reaches the output register one cycle earlier.
//
// Ports
//   CLK, RST_N                : clock, asynchronous active-low reset
//   RSP_VLD/RSP_RDY           : response handshake
//   RSP_SLICE/SEL/SIZE/SIGNED/ADDR_LO/DATA : response fields
//   LOAD_HOLD                 : inhibit FIFO pop this cycle
//   PEND_SET_VLD/SLICE/SEL    : mark a register pending when a load issues
//   RACCOON_LOAD_VLD/SLICE/SEL/RACCOON_LOAD : registered register-file write
//   PEND                      : scoreboard, bit index {slice, sel}
//   PEND_ERR, ALIGN_ERR       : sticky error flags

module tawas_rcn_load_return #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RSP_VLD,
  output logic        RSP_RDY,
  input  logic [1:0]  RSP_SLICE,
  input  logic [2:0]  RSP_SEL,
  input  logic [1:0]  RSP_SIZE,
  input  logic        RSP_SIGNED,
  input  logic [1:0]  RSP_ADDR_LO,
  input  logic [31:0] RSP_DATA,
  input  logic        LOAD_HOLD,
  input  logic        PEND_SET_VLD,
  input  logic [1:0]  PEND_SET_SLICE,
  input  logic [2:0]  PEND_SET_SEL,
  output logic        RACCOON_LOAD_VLD,
  output logic [1:0]  RACCOON_LOAD_SLICE,
  output logic [2:0]  RACCOON_LOAD_SEL,
  output logic [31:0] RACCOON_LOAD,
  output logic [31:0] PEND,
  output logic        PEND_ERR,
  output logic        ALIGN_ERR
);

  typedef struct packed {
    logic [1:0]  slice;
    logic [2:0]  sel;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  addr_lo;
    logic [31:0] data;
  } rsp_t;

  localparam logic [PTR_W:0] CntFull = (PTR_W + 1)'(DEPTH);

  rsp_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic        out_vld_q;
  logic [1:0]  out_slice_q;
  logic [2:0]  out_sel_q;
  logic [31:0] out_data_q;
  logic [31:0] pend_q, pend_d;
  logic        pend_err_q, pend_err_d;
  logic        align_err_q;

  rsp_t in_rsp, head, out_rsp;
  logic push, pop, bypass, fifo_wr, out_fire;
  logic [4:0] set_idx, clr_idx;

  // Align and extend a response into register-file format.
  function automatic logic [31:0] fmt(input rsp_t r);
    logic [7:0]  b;
    logic [15:0] h;
    case (r.addr_lo)
      2'd0:    b = r.data[7:0];
      2'd1:    b = r.data[15:8];
      2'd2:    b = r.data[23:16];
      default: b = r.data[31:24];
    endcase
    // A misaligned half (addr_lo[0]=1) is treated as if bit 0 were clear.
    h = r.addr_lo[1] ? r.data[31:16] : r.data[15:0];
    case (r.size)
      2'd0:    fmt = {{24{r.sgn & b[7]}}, b};
      2'd1:    fmt = {{16{r.sgn & h[15]}}, h};
      default: fmt = r.data;
    endcase
  endfunction

  assign in_rsp = '{slice: RSP_SLICE, sel: RSP_SEL, size: RSP_SIZE, sgn: RSP_SIGNED,
                    addr_lo: RSP_ADDR_LO, data: RSP_DATA};
  assign head   = mem_q[rd_ptr_q];

  // Ready comes from the registered count only; forced low during reset.
  assign RSP_RDY = RST_N && (count_q != CntFull);
  assign push    = RSP_VLD && RSP_RDY;
  assign pop     = (count_q != '0) && !LOAD_HOLD;

`ifdef TAWAS_RCN_LOAD_BYPASS_EN
  assign bypass = push && (count_q == '0) && !LOAD_HOLD;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_wr  = push && !bypass;
  // pop needs a non-empty FIFO and bypass an empty one, so they never coincide.
  assign out_fire = pop || bypass;
  assign out_rsp  = bypass ? in_rsp : head;

  assign set_idx = {PEND_SET_SLICE, PEND_SET_SEL};
  assign clr_idx = {out_rsp.slice, out_rsp.sel};

  always_comb begin
    count_d = count_q;
    case ({fifo_wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Clear first, then set, so a same-edge set wins.
  always_comb begin
    pend_d     = pend_q;
    pend_err_d = pend_err_q;
    if (out_fire) pend_d[clr_idx] = 1'b0;
    if (PEND_SET_VLD) begin
      if (pend_q[set_idx] && !(out_fire && (clr_idx == set_idx))) pend_err_d = 1'b1;
      pend_d[set_idx] = 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= in_rsp;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_vld_q   <= 1'b0;
      out_slice_q <= '0;
      out_sel_q   <= '0;
      out_data_q  <= '0;
      pend_q      <= '0;
      pend_err_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
      out_vld_q  <= out_fire;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (out_fire) begin
        out_slice_q <= out_rsp.slice;
        out_sel_q   <= out_rsp.sel;
        out_data_q  <= fmt(out_rsp);
        if (out_rsp.size == 2'd1 && out_rsp.addr_lo[0]) align_err_q <= 1'b1;
      end
    end
  end

  assign RACCOON_LOAD_VLD   = out_vld_q;
  assign RACCOON_LOAD_SLICE = out_slice_q;
  assign RACCOON_LOAD_SEL   = out_sel_q;
  assign RACCOON_LOAD       = out_data_q;
  assign PEND               = pend_q;
  assign PEND_ERR           = pend_err_q;
  assign ALIGN_ERR          = align_err_q;

endmodule

// File: doc/tawas_rcn_load_return.md
Name: tawas_rcn_load_return

Overview:
- Return stage between the Raccoon bus master and the register file's RACCOON_LOAD write port.
- Buffers Raccoon load responses in a FIFO and aligns/extends each byte, halfword or word.
- Issues at most one register-file write per cycle, targeting the owning slice and register.
- Keeps a per-slice, per-register pending-load scoreboard so the decode stage can stall on registers with loads in flight.

Parameters:
DEPTH, 4, response FIFO entries; power of two, minimum 2.
PTR_W, 2, log2(DEPTH).

Ports:
CLK  in  1  core clock.
RST_N  in  1  asynchronous active-low reset.
RSP_VLD  in  1  Raccoon load response valid.
RSP_RDY  out  1  FIFO can accept a response.
RSP_SLICE  in  2  owning slice.
RSP_SEL  in  3  destination register.
RSP_SIZE  in  2  0=byte, 1=half, 2/3=word.
RSP_SIGNED  in  1  sign-extend byte/half.
RSP_ADDR_LO  in  2  byte address bits [1:0].
RSP_DATA  in  32  raw little-endian bus word.
LOAD_HOLD  in  1  inhibit pop this cycle (register-file port reserved).
PEND_SET_VLD  in  1  load issued; mark register pending.
PEND_SET_SLICE  in  2  slice of issued load.
PEND_SET_SEL  in  3  register of issued load.
RACCOON_LOAD_VLD  out  1  register-file write strobe.
RACCOON_LOAD_SLICE  out  2  write slice.
RACCOON_LOAD_SEL  out  3  write register.
RACCOON_LOAD  out  32  formatted write data.
PEND  out  32  scoreboard; bit index = {slice, sel}.
PEND_ERR  out  1  sticky: set on an already-pending bit.
ALIGN_ERR  out  1  sticky: halfword with RSP_ADDR_LO[0]=1.

Behaviour:
- **Reset.** Asynchronous on RST_N low. FIFO count and pointers = 0; all outputs = 0, including RSP_RDY, which is forced low while RST_N is low.
- **Push.** RSP_RDY = (count != DEPTH), from the registered count only. An entry is pushed on RSP_VLD && RSP_RDY. When full, no push occurs, even if a pop happens in the same cycle.
- **Pop.** Occurs when count != 0 && !LOAD_HOLD. The head is formatted and registered onto the RACCOON_LOAD_* outputs. RACCOON_LOAD_VLD is high for exactly one cycle per pop and is 0 in any cycle with no pop.
- **Latency.** Response accepted in cycle N gives RACCOON_LOAD_VLD in cycle N+2 at the earliest. Throughput is one write per cycle.
- **Simultaneous push and pop.** Count is unchanged. Pointers wrap modulo DEPTH.
- **LOAD_HOLD.** Freezes the FIFO head only; pushes continue until full.
- **Formatting, byte (size 0).** Lane RSP_ADDR_LO selects bits [8a+7:8a]. The value is zero- or sign-extended according to RSP_SIGNED.
- **Formatting, half (size 1).** RSP_ADDR_LO[1] selects the half. If RSP_ADDR_LO[0]=1, ALIGN_ERR is set and the access is treated as if bit 0 were 0.
- **Formatting, word.** Data passes unchanged; RSP_ADDR_LO is ignored.
- **Scoreboard set.** PEND_SET_VLD sets PEND[{slice,sel}] at the clock edge.
- **Scoreboard clear.** The edge that raises RACCOON_LOAD_VLD also clears the matching bit.
- **Scoreboard collisions.** If set and clear target the same bit on the same edge, set wins. If a set targets a bit already 1 (and not being cleared that edge), PEND_ERR is set.
- **Sticky errors.** PEND_ERR and ALIGN_ERR clear only on reset.
- **Reset mid-operation.** FIFO contents are discarded, PEND is cleared and any pending write strobe is dropped.

Optional Feature:
- Macro: TAWAS_RCN_LOAD_BYPASS_EN.
- **Defined.** If count == 0 && !LOAD_HOLD when a response is accepted, that response bypasses the FIFO and is formatted straight into the output register. Latency is N+1 and the FIFO pointers do not move.
- **Undefined.** Every response passes through the FIFO; minimum latency is N+2.
- Ordering is preserved in both builds.

Test Plan:
- **Signed byte.** Reset, then a single response: slice 2, sel 5, size 0, signed, addr_lo 3, data 0x80123456 -> cycle N+2 (N+1 with bypass): VLD=1, SLICE=2, SEL=5, LOAD=0xFFFFFF80.
- **Unsigned half.** Addr_lo 2, data 0xBEEF1234 -> LOAD=0x0000BEEF. Repeat with addr_lo 1 -> ALIGN_ERR=1 and LOAD=0x00001234.
- **Hold and fill.** Hold LOAD_HOLD=1 and push 5 responses at DEPTH=4 -> RSP_RDY=0 after 4 accepts. Release -> 4 writes on consecutive cycles in order, then the 5th.
- **Scoreboard.** PEND_SET slice 1, sel 3 -> PEND=0x00000800. Matching write -> PEND=0. Set and clear of the same bit on one edge -> bit stays 1. Second set on a pending bit -> PEND_ERR=1.
- **Reset mid-operation.** Pull RST_N low with 3 entries queued -> all outputs 0 immediately and RSP_RDY=0. After release: RSP_RDY=1, no stale writes.
